// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryptor with a fixed key. It computes one
// round per clock and starts a new block every 11 cycles.
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   d       plaintext block, byte 0 in d[127:120]; sampled only when rc=0
//   fout    registered ciphertext digest byte, updated on the rc=10 edge
//   k1..k10 expanded round keys of KEY (combinational constants)
// Build option: AES_FOUT_XOR_EN selects fout = XOR of all 16 ciphertext
// bytes. Without it, fout = ciphertext byte 15.
module aes_top #(
  parameter logic [127:0] KEY = 128'hb9cef3df1e2157eeaf1f997b124c8cb4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] d,
  output logic [7:0]   fout,
  output logic [127:0] k1,
  output logic [127:0] k2,
  output logic [127:0] k3,
  output logic [127:0] k4,
  output logic [127:0] k5,
  output logic [127:0] k6,
  output logic [127:0] k7,
  output logic [127:0] k8,
  output logic [127:0] k9,
  output logic [127:0] k10
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // The inverse is x^254, built from x^2 * x^4 * ... * x^128. It yields 0 for x=0,
  // which is what the S-box requires. The affine step is the rotate-and-XOR form.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < i; j++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc_b);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {k[23:0], k[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc_b, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Key schedule. It depends only on the parameter and folds to constants.
  logic [10:0][127:0] rk;
  assign rk[0] = KEY;
  for (genvar gi = 1; gi <= 10; gi++) begin : g_ks
    assign rk[gi] = next_key(rk[gi-1], rcon(gi));
  end

  assign k1  = rk[1];
  assign k2  = rk[2];
  assign k3  = rk[3];
  assign k4  = rk[4];
  assign k5  = rk[5];
  assign k6  = rk[6];
  assign k7  = rk[7];
  assign k8  = rk[8];
  assign k9  = rk[9];
  assign k10 = rk[10];

  logic [3:0]   rc, rc_nxt;
  logic [127:0] st, res, ks;
  logic [7:0]   dg;
  logic [7:0]   sub [16];
  logic [7:0]   shr [16];
  logic [7:0]   mix [16];

  // State register: round counter, round state and the digest output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc   <= 4'd0;
      st   <= '0;
      fout <= 8'h00;
    end else begin
      rc <= rc_nxt;
      if (rc == 4'd0)       st   <= d ^ KEY;
      else if (rc <= 4'd9)  st   <= res;
      else if (rc == 4'd10) fout <= dg;
    end
  end

  // Next-state logic. Any count past 10, including a corrupted value, returns to 0.
  always_comb begin
    rc_nxt = rc + 4'd1;
    if (rc >= 4'd10) rc_nxt = 4'd0;
  end

  // Round datapath. Byte n lives at st[127-8n -: 8]. Column c holds bytes 4c..4c+3.
  always_comb begin
    ks  = '0;
    res = '0;
    dg  = 8'h00;
    for (int i = 1; i <= 10; i++)
      if (rc == 4'(i)) ks = rk[i];
    for (int n = 0; n < 16; n++)
      sub[n] = sbox(st[127-8*n -: 8]);
    // ShiftRows: row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shr[r+4*c] = sub[r + 4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      mix[4*c]   = xtime(shr[4*c]) ^ xtime(shr[4*c+1]) ^ shr[4*c+1] ^ shr[4*c+2] ^ shr[4*c+3];
      mix[4*c+1] = shr[4*c] ^ xtime(shr[4*c+1]) ^ xtime(shr[4*c+2]) ^ shr[4*c+2] ^ shr[4*c+3];
      mix[4*c+2] = shr[4*c] ^ shr[4*c+1] ^ xtime(shr[4*c+2]) ^ xtime(shr[4*c+3]) ^ shr[4*c+3];
      mix[4*c+3] = xtime(shr[4*c]) ^ shr[4*c] ^ shr[4*c+1] ^ shr[4*c+2] ^ xtime(shr[4*c+3]);
    end
    for (int n = 0; n < 16; n++)
      res[127-8*n -: 8] = ((rc == 4'd10) ? shr[n] : mix[n]) ^ ks[127-8*n -: 8];
`ifdef AES_FOUT_XOR_EN
    for (int n = 0; n < 16; n++)
      dg = dg ^ res[127-8*n -: 8];
`else
    dg = res[7:0];
`endif
  end

endmodule

// File: tb/tb_aes_top.sv
module tb_aes_top;
  localparam logic [127:0] KEYF = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEYD = 128'hb9cef3df1e2157eeaf1f997b124c8cb4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] d;
  logic [7:0]   fout_f, fout_d;
  logic [127:0] kf [1:10];
  logic [127:0] kd [1:10];

  int nchk = 0;
  int nerr = 0;
  logic [7:0] sb [256];
  logic [7:0] exp_f, exp_d;

  always #5 clk = ~clk;

  aes_top #(.KEY(KEYF)) u_fips (
    .clk(clk), .rst_n(rst_n), .d(d), .fout(fout_f),
    .k1(kf[1]), .k2(kf[2]), .k3(kf[3]), .k4(kf[4]), .k5(kf[5]),
    .k6(kf[6]), .k7(kf[7]), .k8(kf[8]), .k9(kf[9]), .k10(kf[10])
  );

  aes_top u_dflt (
    .clk(clk), .rst_n(rst_n), .d(d), .fout(fout_d),
    .k1(kd[1]), .k2(kd[2]), .k3(kd[3]), .k4(kd[4]), .k5(kd[5]),
    .k6(kd[6]), .k7(kd[7]), .k8(kd[8]), .k9(kd[9]), .k10(kd[10])
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Software reference model. The S-box is built by brute-force inverse search.
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    logic [8:0] t;
    t = {a, 1'b0};
    if (t[8]) t = t ^ 9'h11b;
    return t[7:0];
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = m_xt(t);
    end
    return r;
  endfunction

  task automatic build_sbox;
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] m_rk(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcn;
    rcn = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcn, 24'h0};
        rcn = m_xt(rcn);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k, o;
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ key[127-8*n -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w + 4*((c+w)%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          t[0] = s[4*c]; t[1] = s[4*c+1]; t[2] = s[4*c+2]; t[3] = s[4*c+3];
          s[4*c]   = m_mul(t[0], 8'h02) ^ m_mul(t[1], 8'h03) ^ t[2] ^ t[3];
          s[4*c+1] = t[0] ^ m_mul(t[1], 8'h02) ^ m_mul(t[2], 8'h03) ^ t[3];
          s[4*c+2] = t[0] ^ t[1] ^ m_mul(t[2], 8'h02) ^ m_mul(t[3], 8'h03);
          s[4*c+3] = m_mul(t[0], 8'h03) ^ t[1] ^ t[2] ^ m_mul(t[3], 8'h02);
        end
      k = m_rk(key, r);
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ k[127-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  function automatic logic [7:0] m_dig(input logic [127:0] ct);
    logic [7:0] x;
    x = 8'h00;
`ifdef AES_FOUT_XOR_EN
    for (int n = 0; n < 16; n++) x = x ^ ct[127-8*n -: 8];
`else
    x = ct[7:0];
`endif
    return x;
  endfunction

  // Runs one block, assuming the next edge has rc=0. d is scrambled on every
  // cycle after the sampling edge. The old digest must hold through edge E+9
  // and the new digest must appear at edge E+10.
  task automatic run_blk(input logic [127:0] pt, input string tag);
    logic [7:0] ef, ed;
    ef = m_dig(m_aes(KEYF, pt));
    ed = m_dig(m_aes(KEYD, pt));
    d = pt;
    tick;
    repeat (9) begin
      d = rnd128();
      tick;
    end
    chk({tag, "_hold_f"}, 128'(fout_f), 128'(exp_f));
    chk({tag, "_hold_d"}, 128'(fout_d), 128'(exp_d));
    d = rnd128();
    tick;
    exp_f = ef;
    exp_d = ed;
    chk({tag, "_f"}, 128'(fout_f), 128'(exp_f));
    chk({tag, "_d"}, 128'(fout_d), 128'(exp_d));
  endtask

  initial begin
    logic [127:0] ct;
    logic [7:0]   xr;
    build_sbox();
    rst_n = 1'b0;
    d     = rnd128();
    repeat (3) tick;

    // Reset state and round keys.
    chk("rst_fout_f", 128'(fout_f), 128'h0);
    chk("rst_fout_d", 128'(fout_d), 128'h0);
    chk("rst_rc_f", 128'(u_fips.rc), 128'h0);
    chk("rst_rc_d", 128'(u_dflt.rc), 128'h0);
    chk("k1_fips", kf[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("k10_fips", kf[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int r = 1; r <= 10; r++) begin
      chk($sformatf("kd%0d", r), kd[r], m_rk(KEYD, r));
      chk($sformatf("kf%0d", r), kf[r], m_rk(KEYF, r));
    end

    // Check the FIPS-197 C.1 vector against hand-known ciphertext constants.
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    chk("model_c1", m_aes(KEYF, 128'h00112233445566778899aabbccddeeff), ct);
`ifdef AES_FOUT_XOR_EN
    xr = 8'h00;
    for (int n = 0; n < 16; n++) xr = xr ^ ct[127-8*n -: 8];
`else
    xr = 8'h5a;
`endif
    exp_f = 8'h00;
    exp_d = 8'h00;
    rst_n = 1'b1;
    run_blk(128'h00112233445566778899aabbccddeeff, "c1");
    chk("c1_const", 128'(fout_f), 128'(xr));

    // Check a couple of other blocks with d scrambled between samples.
    run_blk(128'hffeeddccbbaa99887766554433221100, "pat1");
    run_blk(128'h0, "zero");

    // Assert reset mid-block at rc=5 for one edge.
    d = 128'h0123456789abcdef0123456789abcdef;
    tick;
    repeat (4) tick;
    chk("mid_rc5", 128'(u_fips.rc), 128'h5);
    rst_n = 1'b0;
    tick;
    chk("mid_fout_f", 128'(fout_f), 128'h0);
    chk("mid_fout_d", 128'(fout_d), 128'h0);
    chk("mid_rc", 128'(u_dflt.rc), 128'h0);
    rst_n = 1'b1;
    exp_f = 8'h00;
    exp_d = 8'h00;
    run_blk(128'h00112233445566778899aabbccddeeff, "post_rst");
    chk("post_rst_const", 128'(fout_f), 128'(xr));

    // Default-key byte stream.
    for (int i = 0; i < 256; i++)
      run_blk({120'h0, 8'(i)}, $sformatf("s%0d", i));

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
